// File: rtl/posit_pkg.sv
// Shared posit decoder definitions: default geometry, field-width helpers,
// the decoded-field record and constant records for the two special values.
package posit_pkg;

  localparam int N_DEF  = 32;
  localparam int ES_DEF = 2;

  // Signed regime width: must hold -(N-1) .. N-2.
  function automatic int kw_of(input int n);
    return $clog2(n) + 1;
  endfunction

  // Fraction width: a word always spends at least sign + 2 regime bits.
  function automatic int fw_of(input int n, input int es);
    return n - 3 - es;
  endfunction

  localparam int KW_DEF = kw_of(N_DEF);
  localparam int FW_DEF = fw_of(N_DEF, ES_DEF);

  typedef struct packed {
    logic                     sign;
    logic                     zero;
    logic                     nar;
    logic signed [KW_DEF-1:0] k;
    logic [ES_DEF-1:0]        exp;
    logic [FW_DEF-1:0]        frac;
  } posit_dec_t;

  function automatic posit_dec_t dec_zero();
    posit_dec_t d;
    d      = '0;
    d.zero = 1'b1;
    return d;
  endfunction

  function automatic posit_dec_t dec_nar();
    posit_dec_t d;
    d      = '0;
    d.sign = 1'b1;
    d.nar  = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Handshake bundle for the posit decoder: raw-word input stream and
// decoded-field output stream.
interface posit_decode_pipe_if
  import posit_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int ES = ES_DEF
);
  localparam int KW = kw_of(N);
  localparam int FW = fw_of(N, ES);

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_posit;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic                 out_zero;
  logic                 out_nar;
  logic signed [KW-1:0] out_k;
  logic [ES-1:0]        out_exp;
  logic [FW-1:0]        out_frac;

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_nar, out_k, out_exp, out_frac
  );

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_nar, out_k, out_exp, out_frac
  );

endinterface

// File: rtl/count_regime.sv
// Combinational leading-run counter: number of consecutive bits equal to B
// starting at the MSB of the word.
module count_regime #(
  parameter int W = 31,
  parameter bit B = 1'b1,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    logic run;
    run   = 1'b1;
    count = '0;
    for (int i = W - 1; i >= 0; i--) begin
      run   = run & (bits[i] == B);
      count = count + CW'(run);
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Three-stage posit decoder: capture/negate, regime count, field extraction.
// All stages advance together; only the valid bits are reset.
module posit_decode_pipe
  import posit_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int ES = ES_DEF
) (
  input logic          clk,
  input logic          rst_n,
  posit_decode_pipe_if.slave bus
);

  localparam int KW = kw_of(N);
  localparam int FW = fw_of(N, ES);
  localparam int MW = $clog2(N);
  localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

  logic s1_valid, s2_valid, s3_valid;
  logic adv;

  assign adv          = !s3_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = s3_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Stage 1: capture, classify and take the magnitude.
  logic         s1_sign, s1_zero, s1_nar;
  logic [N-1:0] s1_abs;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= bus.in_posit[N-1];
      s1_zero <= (bus.in_posit == '0);
      s1_nar  <= (bus.in_posit == NAR_WORD);
      s1_abs  <= bus.in_posit[N-1] ? -bus.in_posit : bus.in_posit;
    end
  end

  // Stage 2: regime run length from whichever counter matches the lead bit.
  logic [N-2:0]  r_cur;
  logic [MW-1:0] m_ones, m_zeros, m_cur;
  logic [KW-1:0] m_ext, k_cur;

  assign r_cur = s1_abs[N-2:0];

  count_regime #(.W(N - 1), .B(1'b1)) u_count_ones (
    .bits  (r_cur),
    .count (m_ones)
  );

  count_regime #(.W(N - 1), .B(1'b0)) u_count_zeros (
    .bits  (r_cur),
    .count (m_zeros)
  );

  assign m_cur = r_cur[N-2] ? m_ones : m_zeros;
  assign m_ext = {1'b0, m_cur};
  assign k_cur = r_cur[N-2] ? (m_ext - KW'(1)) : (KW'(0) - m_ext);

  logic                 s2_sign, s2_zero, s2_nar;
  logic signed [KW-1:0] s2_k;
  logic [MW-1:0]        s2_m;
  logic [N-2:0]         s2_r;

  always_ff @(posedge clk) begin
    if (adv) begin
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_nar  <= s1_nar;
      s2_k    <= k_cur;
      s2_m    <= m_cur;
      s2_r    <= r_cur;
    end
  end

  // Stage 3: shift out run + terminator; a full-width run shifts to zero.
  logic [MW:0]  sh;
  logic [N-2:0] t;
  logic         special;

  assign sh      = {1'b0, s2_m} + (MW + 1)'(1);
  assign t       = s2_r << sh;
  assign special = s2_zero | s2_nar;

  logic                 s3_sign, s3_zero, s3_nar;
  logic signed [KW-1:0] s3_k;
  logic [ES-1:0]        s3_exp;
  logic [FW-1:0]        s3_frac;

  always_ff @(posedge clk) begin
    if (adv) begin
      s3_sign <= s2_nar | (s2_sign & ~s2_zero);
      s3_zero <= s2_zero;
      s3_nar  <= s2_nar;
      s3_k    <= special ? '0 : s2_k;
      s3_exp  <= special ? '0 : t[N-2 -: ES];
      s3_frac <= special ? '0 : t[N-2-ES -: FW];
    end
  end

  assign bus.out_sign = s3_sign;
  assign bus.out_zero = s3_zero;
  assign bus.out_nar  = s3_nar;
  assign bus.out_k    = s3_k;
  assign bus.out_exp  = s3_exp;
  assign bus.out_frac = s3_frac;

  // The magnitude MSB and the two bits below the fraction never reach an output.
  logic unused_bits;
  assign unused_bits = ^{s1_abs[N-1], t[1:0]};

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed + random bench for posit_decode_pipe (N=32, ES=2) with a
// bit-walking reference decoder feeding an in-order scoreboard.
module tb_posit_decode_pipe;
  import posit_pkg::*;

  localparam int N  = 32;
  localparam int ES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  posit_decode_pipe_if #(.N(N), .ES(ES)) bus ();

  posit_decode_pipe #(.N(N), .ES(ES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          n_acc     = 0;
  logic [31:0] send_q[$];
  posit_dec_t  sb[$];
  bit          held_valid = 1'b0;
  posit_dec_t  held;

  // Reference decoder: walks the magnitude bit by bit.
  function automatic posit_dec_t model(input logic [31:0] p);
    posit_dec_t  d;
    logic [31:0] a;
    int          m, pos;
    logic        lead;
    d = '0;
    if (p == 32'h0) return dec_zero();
    if (p == 32'h8000_0000) return dec_nar();
    d.sign = p[31];
    a      = p[31] ? (~p + 32'd1) : p;
    lead   = a[30];
    m      = 0;
    for (int i = 30; i >= 0; i--) begin
      if (a[i] != lead) break;
      m++;
    end
    d.k = lead ? KW_DEF'(m - 1) : KW_DEF'(-m);
    pos = 30 - m - 1;
    for (int i = 0; i < ES_DEF; i++)
      d.exp[ES_DEF-1-i] = (pos - i >= 0) ? a[pos-i] : 1'b0;
    pos = pos - ES_DEF;
    for (int i = 0; i < FW_DEF; i++)
      d.frac[FW_DEF-1-i] = (pos - i >= 0) ? a[pos-i] : 1'b0;
    return d;
  endfunction

  function automatic posit_dec_t cur_out();
    posit_dec_t d;
    d.sign = bus.out_sign;
    d.zero = bus.out_zero;
    d.nar  = bus.out_nar;
    d.k    = bus.out_k;
    d.exp  = bus.out_exp;
    d.frac = bus.out_frac;
    return d;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input posit_dec_t obs, input posit_dec_t exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, sample handshakes at negedge, settle scoreboard after the edge.
  task automatic cycle(input bit rdy);
    bit         acc, oxfer;
    posit_dec_t got, exp;
    logic [31:0] w;
    bus.out_ready = rdy;
    bus.in_valid  = (send_q.size() > 0);
    bus.in_posit  = (send_q.size() > 0) ? send_q[0] : 32'h0;
    @(negedge clk);
    acc   = bus.in_valid && bus.in_ready;
    oxfer = bus.out_valid && bus.out_ready;
    got   = cur_out();
    if (held_valid) begin
      chk1("hold_valid", bus.out_valid, 1'b1);
      chkd("hold_data", got, held);
    end
    held_valid = bus.out_valid && !bus.out_ready;
    held       = got;
    @(posedge clk);
    #1;
    if (acc) begin
      w = send_q.pop_front();
      sb.push_back(model(w));
      n_acc++;
    end
    if (oxfer) begin
      chk1("out_has_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        $display("xfer out: got %h expected %h", got, exp);
        chkd("out_data", got, exp);
      end
    end
  endtask

  task automatic drain(input bit rnd);
    int budget;
    budget = 400;
    while ((send_q.size() > 0 || sb.size() > 0) && budget > 0) begin
      cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      budget--;
    end
    chk1("drain_done", budget > 0, 1'b1);
  endtask

  task automatic latency_check(input logic [31:0] w);
    send_q.push_back(w);
    cycle(1'b1);
    chk1("lat_accept", send_q.size() == 0, 1'b1);
    chk1("lat_edge0", bus.out_valid, 1'b0);
    cycle(1'b1);
    chk1("lat_edge1", bus.out_valid, 1'b0);
    cycle(1'b1);
    chk1("lat_edge2", bus.out_valid, 1'b1);
    cycle(1'b1);
    chk1("lat_drained", sb.size() == 0, 1'b1);
  endtask

  logic [31:0] dir_words [9];
  int          acc_base;

  initial begin
    dir_words = '{32'h4000_0000, 32'h5000_0000, 32'h4800_0000, 32'hC000_0000,
                  32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000,
                  32'h3C00_0000};
    bus.in_valid  = 1'b0;
    bus.in_posit  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("post_rst_in_ready", bus.in_ready, 1'b1);
    chk1("post_rst_out_valid", bus.out_valid, 1'b0);

    // Known reference points (these fixed expectations also cross-check the model)
    chkd("model_one", model(32'h4000_0000), posit_dec_t'(0));
    chkd("model_max", model(32'h7FFF_FFFF), posit_dec_t'({3'b000, 6'sd30, 2'd0, 27'd0}));
    chkd("model_min", model(32'h0000_0001), posit_dec_t'({3'b000, -6'sd30, 2'd0, 27'd0}));
    chkd("model_four", model(32'h5000_0000), posit_dec_t'({3'b000, 6'sd0, 2'd2, 27'd0}));
    chkd("model_two", model(32'h4800_0000), posit_dec_t'({3'b000, 6'sd0, 2'd1, 27'd0}));

    // Latency of a single word, then directed boundary words back-to-back
    latency_check(32'h4000_0000);
    foreach (dir_words[i]) send_q.push_back(dir_words[i]);
    drain(1'b0);

    // Random words with random backpressure
    for (int i = 0; i < 8; i++) send_q.push_back($urandom);
    drain(1'b1);
    repeat (3) cycle(1'b1);
    chk1("no_extra_out", bus.out_valid, 1'b0);

    // Full pipeline with consumer stalled
    acc_base = n_acc;
    for (int i = 0; i < 4; i++) send_q.push_back($urandom);
    repeat (3) cycle(1'b0);
    chk1("stall_in_ready_low", bus.in_ready, 1'b0);
    repeat (3) cycle(1'b0);
    chk1("stall_accept_count", (n_acc - acc_base) == 3, 1'b1);
    chk1("stall_out_valid", bus.out_valid, 1'b1);
    drain(1'b0);

    // Asynchronous reset with words in flight
    send_q.push_back(32'h3C00_0000);
    send_q.push_back(32'h1234_5678);
    repeat (3) cycle(1'b0);
    chk1("pre_rst_out_valid", bus.out_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
    sb.delete();
    send_q.delete();
    held_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("after_rst_in_ready", bus.in_ready, 1'b1);
    chk1("after_rst_out_valid", bus.out_valid, 1'b0);
    latency_check(32'hB800_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
